vga_fb_arbiter: RTL and testbench

- Shares one single-port frame-buffer RAM between the display scan-out path and a drawing-engine requester.
- Consumes hcount/vcount/hs/vs from the VGA timing generator.
- Display reads take absolute priority during active video. Draw writes are granted only in slots where the display does not need the RAM.
- Delays hs/vs/de so they align with the returned pixel data at the DAC output.

---
 rtl/vga_fb_arbiter_pkg.sv | 18 +
 rtl/vga_fb_arbiter_sync_delay.sv | 33 +++
 rtl/vga_fb_arbiter.sv | 132 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants, pixel type and arbiter state encoding for the VGA frame-buffer arbiter.
package vga_pkg;
    localparam int H_DISP   = 640;
    localparam int V_DISP   = 480;
    localparam int CNT_W    = 11;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 12;
    localparam int PIPE_LAT = 3;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DISP    = 2'd1,
        S_DRAW    = 2'd2,
        S_RECOVER = 2'd3
    } arb_state_t;
endpackage

// File: rtl/vga_fb_arbiter_sync_delay.sv
// N-stage delay line for {de, hs, vs}; resets to the blanking levels de=0, hs=1, vs=1.
module vga_sync_delay #(
    parameter int N = 3
) (
    input  logic pixel_clk,
    input  logic rst_n,
    input  logic de,
    input  logic hs,
    input  logic vs,
    output logic de_dly,
    output logic hs_dly,
    output logic vs_dly
);
    logic [N-1:0] de_q;
    logic [N-1:0] hs_q;
    logic [N-1:0] vs_q;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q <= '0;
            hs_q <= '1;
            vs_q <= '1;
        end else begin
            de_q <= {de_q[N-2:0], de};
            hs_q <= {hs_q[N-2:0], hs};
            vs_q <= {vs_q[N-2:0], vs};
        end
    end

    assign de_dly = de_q[N-1];
    assign hs_dly = hs_q[N-1];
    assign vs_dly = vs_q[N-1];
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display scan-out owns active slots, draw requests use blank slots.
// Optional draw readback is enabled with the VGA_FB_READBACK_EN macro.
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  hcount,
    input  logic [CNT_W-1:0]  vcount,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              drw_req,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_wdata,
    input  logic              drw_we,
    output logic              drw_ack,
    output logic [DATA_W-1:0] drw_rdata,
    output logic              drw_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_rgb,
    output logic              pix_de,
    output logic              pix_hs,
    output logic              pix_vs
);
    // Draw handshake: the requester holds drw_req with addr/data/we stable until drw_ack;
    // drw_ack pulses in the cycle the access is on the RAM port, and dropping drw_req
    // before that cancels the request.
    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              active;
    logic              grant;
    logic              drw_is_wr;
    logic [ADDR_W-1:0] disp_addr;
    pixel_t            rgb_q;

    assign active    = (hcount < CNT_W'(H_DISP)) && (vcount < CNT_W'(V_DISP));
    assign disp_addr = ADDR_W'(vcount) * ADDR_W'(H_DISP) + ADDR_W'(hcount);

`ifdef VGA_FB_READBACK_EN
    assign drw_is_wr = drw_we;
`else
    logic unused_drw_we;
    assign unused_drw_we = drw_we;
    assign drw_is_wr     = 1'b1;
`endif

    // A blank slot may be granted from S_DISP too, so the first blank slot after a line is usable.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            S_IDLE, S_DISP: begin
                if (active) begin
                    state_nxt = S_DISP;
                end else if (drw_req) begin
                    state_nxt = S_DRAW;
                    grant     = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAW:    state_nxt = S_RECOVER;
            S_RECOVER: state_nxt = active ? S_DISP : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            drw_ack   <= 1'b0;
            rgb_q     <= '0;
        end else begin
            state   <= state_nxt;
            drw_ack <= grant;
            rgb_q   <= mem_rdata;
            if (active) begin
                mem_addr <= disp_addr;
                mem_we   <= 1'b0;
            end else if (grant) begin
                mem_addr  <= drw_addr;
                mem_we    <= drw_is_wr;
                mem_wdata <= drw_wdata;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

`ifdef VGA_FB_READBACK_EN
    logic rd_pend;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            drw_rvalid <= 1'b0;
            drw_rdata  <= '0;
        end else begin
            rd_pend    <= drw_ack && !mem_we;
            drw_rvalid <= rd_pend;
            if (rd_pend) begin
                drw_rdata <= mem_rdata;
            end
        end
    end
`else
    assign drw_rdata  = '0;
    assign drw_rvalid = 1'b0;
`endif

    vga_sync_delay #(
        .N (PIPE_LAT)
    ) u_sync_delay (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .de        (active),
        .hs        (hs_in),
        .vs        (vs_in),
        .de_dly    (pix_de),
        .hs_dly    (pix_hs),
        .vs_dly    (pix_vs)
    );

    // Blanking level is forced to zero regardless of what the RAM returns.
    assign pix_rgb = pix_de ? rgb_q : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed steps plus randomized scan, checked against a cycle-indexed model.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int HN = 8192;

    logic              pixel_clk = 1'b0;
    logic              rst_n;
    logic [CNT_W-1:0]  hcount;
    logic [CNT_W-1:0]  vcount;
    logic              hs_in;
    logic              vs_in;
    logic              drw_req;
    logic [ADDR_W-1:0] drw_addr;
    logic [DATA_W-1:0] drw_wdata;
    logic              drw_we;
    logic              drw_ack;
    logic [DATA_W-1:0] drw_rdata;
    logic              drw_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pix_rgb;
    logic              pix_de;
    logic              pix_hs;
    logic              pix_vs;

    always #5 pixel_clk = ~pixel_clk;

    vga_fb_arbiter dut (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .drw_req    (drw_req),
        .drw_addr   (drw_addr),
        .drw_wdata  (drw_wdata),
        .drw_we     (drw_we),
        .drw_ack    (drw_ack),
        .drw_rdata  (drw_rdata),
        .drw_rvalid (drw_rvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_rgb    (pix_rgb),
        .pix_de     (pix_de),
        .pix_hs     (pix_hs),
        .pix_vs     (pix_vs)
    );

    // Power-on frame-buffer content: two fixed words, the rest a hash of the address.
    function automatic logic [11:0] pat(input int a);
        if (a == 1285) return 12'hABC;
        if (a == 7) return 12'h123;
        return 12'(a * 37 + 5) | 12'h001;
    endfunction

    // Synchronous single-port RAM, read-before-write.
    logic [DATA_W-1:0] ram [int];
    always @(posedge pixel_clk) begin
        logic [DATA_W-1:0] rd;
        rd = ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pat(int'(mem_addr));
        mem_rdata <= rd;
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    end

    // Reference model: per-cycle input history and expected frame-buffer content.
    logic [DATA_W-1:0] mm [int];
    logic        act_h [HN];
    logic        hs_h  [HN];
    logic        vs_h  [HN];
    logic        req_h [HN];
    logic        we_h  [HN];
    logic        ackx  [HN];
    logic        rdv   [HN];
    int          addr_h [HN];
    int          dispa_h [HN];
    logic [11:0] wd_h  [HN];
    logic [11:0] pixv  [HN];
    logic [11:0] rdval [HN];
    int          cyc;
    int          base;
    int          exp_addr;
    logic [11:0] exp_wdata;
    logic [11:0] exp_rdata;
    int          n_tests;
    int          n_fail;

    typedef struct {
        int          addr;
        logic [11:0] data;
        logic        we;
    } req_t;
    req_t req_q[$];

    function automatic logic [11:0] mm_get(input int a);
        return mm.exists(a) ? mm[a] : pat(a);
    endfunction

    function automatic logic act_at(input int j);
        return (j < base) ? 1'b0 : act_h[j];
    endfunction

    function automatic logic hs_at(input int j);
        return (j < base) ? 1'b1 : hs_h[j];
    endfunction

    function automatic logic vs_at(input int j);
        return (j < base) ? 1'b1 : vs_h[j];
    endfunction

    function automatic logic ack_at(input int j);
        return (j <= base) ? 1'b0 : ackx[j];
    endfunction

    function automatic logic rdv_at(input int j);
        return (j <= base) ? 1'b0 : rdv[j];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        if (req_q.size() > 0) begin
            drw_req   = 1'b1;
            drw_addr  = ADDR_W'(req_q[0].addr);
            drw_wdata = req_q[0].data;
            drw_we    = req_q[0].we;
        end else begin
            drw_req = 1'b0;
        end
    endtask

    task automatic push_req(input int a, input logic [11:0] d, input logic we);
        req_t r;
        r.addr = a;
        r.data = d;
        r.we   = we;
        req_q.push_back(r);
        drive_req();
    endtask

    // Expected outputs at sample k from the input history of earlier periods.
    task automatic check_sample();
        int          k;
        logic        ae;
        logic        e_ack;
        logic        wr;
        logic        e_de;
        logic        e_rv;
        k     = cyc;
        ae    = act_h[k-1];
        e_ack = req_h[k-1] && !ae && !ack_at(k-1) && !ack_at(k-2);
        ackx[k] = e_ack;
`ifdef VGA_FB_READBACK_EN
        wr = e_ack && we_h[k-1];
`else
        wr = e_ack;
`endif
        if (ae) exp_addr = dispa_h[k-1];
        else if (e_ack) exp_addr = addr_h[k-1];
        if (e_ack) exp_wdata = wd_h[k-1];
        rdv[k]   = e_ack && !wr;
        rdval[k] = mm_get(addr_h[k-1]);
        if (wr) mm[addr_h[k-1]] = wd_h[k-1];
        e_rv = rdv_at(k-2);
        if (e_rv) exp_rdata = rdval[k-2];
        e_de = act_at(k-3);

        chk("drw_ack", 32'(drw_ack), 32'(e_ack));
        chk("mem_we", 32'(mem_we), 32'(wr));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (e_ack) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        chk("pix_de", 32'(pix_de), 32'(e_de));
        chk("pix_hs", 32'(pix_hs), 32'(hs_at(k-3)));
        chk("pix_vs", 32'(pix_vs), 32'(vs_at(k-3)));
        chk("pix_rgb", 32'(pix_rgb), e_de ? 32'(pixv[k-3]) : 32'd0);
        chk("drw_rvalid", 32'(drw_rvalid), 32'(e_rv));
        chk("drw_rdata", 32'(drw_rdata), 32'(exp_rdata));
    endtask

    task automatic step();
        int da;
        act_h[cyc]  = (int'(hcount) < H_DISP) && (int'(vcount) < V_DISP);
        da          = (int'(vcount) * H_DISP + int'(hcount)) & ((1 << ADDR_W) - 1);
        dispa_h[cyc] = da;
        pixv[cyc]   = act_h[cyc] ? mm_get(da) : 12'h000;
        hs_h[cyc]   = hs_in;
        vs_h[cyc]   = vs_in;
        req_h[cyc]  = drw_req;
        addr_h[cyc] = int'(drw_addr);
        wd_h[cyc]   = drw_wdata;
        we_h[cyc]   = drw_we;
        @(posedge pixel_clk);
        #1;
        cyc++;
        if (cyc >= HN) begin
            $display("FAIL cycle_budget: observed %0d, expected < %0d", cyc, HN);
            $fatal(1, "cycle budget exhausted");
        end
        check_sample();
        if (drw_ack && req_q.size() > 0) void'(req_q.pop_front());
        drive_req();
    endtask

    task automatic set_pos(input int h, input int v);
        hcount = CNT_W'(h);
        vcount = CNT_W'(v);
    endtask

    initial begin
        int   early_acks;
        int   wr_cnt;
        int   ack_cyc[$];
        logic got;
        int   h;
        int   v;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        base    = 0;
        exp_addr  = 0;
        exp_wdata = '0;
        exp_rdata = '0;
        rst_n     = 1'b1;
        set_pos(700, 0);
        hs_in     = 1'b1;
        vs_in     = 1'b1;
        drw_req   = 1'b0;
        drw_addr  = '0;
        drw_wdata = '0;
        drw_we    = 1'b1;

        // Power-on reset: outputs settle without any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst0_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("rst0_pix_de", 32'(pix_de), 32'd0);
        chk("rst0_pix_hs", 32'(pix_hs), 32'd1);
        chk("rst0_pix_vs", 32'(pix_vs), 32'd1);
        chk("rst0_drw_ack", 32'(drw_ack), 32'd0);
        chk("rst0_mem_we", 32'(mem_we), 32'd0);
        chk("rst0_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge pixel_clk);
        @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;
        base  = cyc;

        // Display fetch at (5,2).
        set_pos(5, 2);
        step();
        chk("fetch_addr", 32'(mem_addr), 32'd1285);
        chk("fetch_we", 32'(mem_we), 32'd0);
        set_pos(700, 2);
        step();
        step();
        chk("fetch_rgb", 32'(pix_rgb), 32'hABC);
        chk("fetch_de", 32'(pix_de), 32'd1);

        // Sync alignment in vblank; RAM keeps returning 12'hABC for the held address.
        set_pos(700, 490);
        step();
        step();
        hs_in = 1'b0;
        step();
        hs_in = 1'b1;
        step();
        chk("hs_t2", 32'(pix_hs), 32'd1);
        step();
        chk("hs_t3", 32'(pix_hs), 32'd0);
        chk("rgb_blank", 32'(pix_rgb), 32'd0);

        // Draw request waits out the active part of line 0.
        set_pos(10, 0);
        push_req(100, 12'h5A5, 1'b1);
        early_acks = 0;
        for (int hh = 10; hh < H_DISP; hh++) begin
            set_pos(hh, 0);
            step();
            if (drw_ack) early_acks++;
        end
        chk("prio_wait", 32'(early_acks), 32'd0);
        set_pos(640, 0);
        step();
        chk("prio_ack", 32'(drw_ack), 32'd1);
        chk("prio_we", 32'(mem_we), 32'd1);
        chk("prio_addr", 32'(mem_addr), 32'd100);

        // Back-to-back writes in vblank.
        for (int i = 0; i < 4; i++) push_req(200 + i, 12'($urandom), 1'b1);
        wr_cnt = 0;
        for (int n = 0; n < 40 && ack_cyc.size() < 4; n++) begin
            set_pos(650 + n, 490);
            step();
            if (drw_ack) ack_cyc.push_back(cyc);
            if (mem_we) wr_cnt++;
        end
        chk("b2b_acks", 32'(ack_cyc.size()), 32'd4);
        chk("b2b_writes", 32'(wr_cnt), 32'd4);
        for (int i = 0; i + 1 < ack_cyc.size(); i++)
            chk("b2b_spacing", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd3);

        // Draw read of address 7.
        set_pos(700, 491);
        push_req(7, 12'h000, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step();
            if (drw_ack) got = 1'b1;
        end
        chk("rb_ack", 32'(got), 32'd1);
        step();
        step();
`ifdef VGA_FB_READBACK_EN
        chk("rb_rvalid", 32'(drw_rvalid), 32'd1);
        chk("rb_rdata", 32'(drw_rdata), 32'h123);
`else
        chk("rb_rvalid_off", 32'(drw_rvalid), 32'd0);
`endif

        // Reset while a write is on the RAM port.
        push_req(300, 12'h077, 1'b1);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step();
            if (drw_ack && mem_we) got = 1'b1;
        end
        chk("rst_inflight", 32'(got), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_drw_ack", 32'(drw_ack), 32'd0);
        chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("rst_pix_de", 32'(pix_de), 32'd0);
        chk("rst_pix_hs", 32'(pix_hs), 32'd1);
        chk("rst_pix_vs", 32'(pix_vs), 32'd1);
        chk("rst_rvalid", 32'(drw_rvalid), 32'd0);
        req_q.delete();
        drive_req();
        set_pos(100, 100);
        repeat (3) @(posedge pixel_clk);
        #1;
        rst_n     = 1'b1;
        base      = cyc;
        exp_addr  = 0;
        exp_wdata = '0;
        exp_rdata = '0;

        // Randomized scan with jumps, random requests and cancellations.
        h = 600;
        v = 470;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                h = $urandom_range(0, 799);
                v = $urandom_range(0, 524);
            end else begin
                h = h + 1;
                if (h == 800) begin
                    h = 0;
                    v = (v + 1) % 525;
                end
            end
            set_pos(h, v);
            hs_in = !(h >= 656 && h < 752);
            vs_in = !(v >= 490 && v < 492);
            if (req_q.size() > 0 && $urandom_range(0, 40) == 0) begin
                void'(req_q.pop_front());
                drive_req();
            end
            if (req_q.size() == 0 && $urandom_range(0, 3) == 0)
                push_req($urandom_range(0, 307199), 12'($urandom), 1'($urandom_range(0, 1)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
